// File: rtl/pwm_reg_scheduler.sv
// Shadow/active register bank for the PWM stage: SPI writes land in shadows and are
// copied to the active set only at a PWM period boundary. Also owns the PWM period counter.
module pwm_reg_scheduler #(
    parameter int PRESCALE = 1,
    parameter int ERR_W    = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic [6:0]       wr_addr,
    input  logic [7:0]       wr_data,
    output logic [15:0]      en_out,
    output logic [15:0]      en_pwm,
    output logic [7:0]       duty,
    output logic [7:0]       pwm_cnt,
    output logic             period_wrap,
    output logic             commit_done,
    output logic [ERR_W-1:0] err_cnt
);

    localparam int          NUM_REGS = 5;
    localparam logic [15:0] PRE_MAX  = 16'(PRESCALE - 1);

    typedef enum logic {
        IDLE,
        COMMIT
    } state_t;

    state_t                      state_reg, state_next;
    logic [2:0]                  idx_reg, idx_next;
    logic [15:0]                 pre_cnt_reg;
    logic [7:0]                  pwm_cnt_reg;
    logic                        period_wrap_reg;
    logic [ERR_W-1:0]            err_cnt_reg;
    logic [NUM_REGS-1:0][7:0]    active_bus;
    logic [NUM_REGS-1:0]         dirty_bus;

    logic wr_accept;
    logic addr_ok;
    logic good_wr;
    logic bad_wr;
    logic pre_tick;
    logic wrap_evt;
    logic in_commit;

    assign wr_ready  = (state_reg == IDLE);
    assign wr_accept = wr_valid && wr_ready;
    assign addr_ok   = (wr_addr <= 7'd4);
    assign good_wr   = wr_accept && addr_ok;
    assign bad_wr    = wr_accept && !addr_ok;
    assign pre_tick  = (pre_cnt_reg == PRE_MAX);
    assign wrap_evt  = pre_tick && (pwm_cnt_reg == 8'hFF);
    assign in_commit = (state_reg == COMMIT);

    // Free-running period counter; keeps stepping through COMMIT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_cnt_reg     <= '0;
            pwm_cnt_reg     <= '0;
            period_wrap_reg <= 1'b0;
        end else begin
            period_wrap_reg <= wrap_evt;
            if (pre_tick) begin
                pre_cnt_reg <= '0;
                pwm_cnt_reg <= pwm_cnt_reg + 8'd1;
            end else begin
                pre_cnt_reg <= pre_cnt_reg + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            idx_reg   <= '0;
        end else begin
            state_reg <= state_next;
            idx_reg   <= idx_next;
        end
    end

    // A write accepted on the boundary cycle lands in its shadow in time for the walk.
    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        case (state_reg)
            IDLE: begin
                idx_next = '0;
                if (wrap_evt && ((|dirty_bus) || good_wr)) begin
                    state_next = COMMIT;
                end
            end
            COMMIT: begin
                if (idx_reg == 3'(NUM_REGS - 1)) begin
                    state_next = IDLE;
                    idx_next   = '0;
                end else begin
                    idx_next = idx_reg + 3'd1;
                end
            end
            default: begin
                state_next = IDLE;
                idx_next   = '0;
            end
        endcase
    end

    // Writes only happen in IDLE and copies only in COMMIT, so the dirty set/clear never collide.
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
        logic [7:0] shadow_reg;
        logic [7:0] active_reg;
        logic       dirty_reg;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                shadow_reg <= '0;
                active_reg <= '0;
                dirty_reg  <= 1'b0;
            end else if (good_wr && (wr_addr == 7'(gi))) begin
                shadow_reg <= wr_data;
                dirty_reg  <= 1'b1;
            end else if (in_commit && (idx_reg == 3'(gi)) && dirty_reg) begin
                active_reg <= shadow_reg;
                dirty_reg  <= 1'b0;
            end
        end

        assign active_bus[gi] = active_reg;
        assign dirty_bus[gi]  = dirty_reg;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_reg <= '0;
        end else if (bad_wr && (err_cnt_reg != {ERR_W{1'b1}})) begin
            err_cnt_reg <= err_cnt_reg + 1'b1;
        end
    end

    assign en_out      = {active_bus[1], active_bus[0]};
    assign en_pwm      = {active_bus[3], active_bus[2]};
    assign duty        = active_bus[4];
    assign pwm_cnt     = pwm_cnt_reg;
    assign period_wrap = period_wrap_reg;
    assign commit_done = in_commit && (idx_reg == 3'(NUM_REGS - 1));
    assign err_cnt     = err_cnt_reg;

endmodule

// File: tb/tb_pwm_reg_scheduler.sv
// Directed bench for pwm_reg_scheduler: expected active-register snapshots are queued as
// writes are issued, and a monitor compares them one cycle after each commit_done pulse.
module tb_pwm_reg_scheduler;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        wr_valid = 1'b0;
    logic        wr_ready;
    logic [6:0]  wr_addr = '0;
    logic [7:0]  wr_data = '0;
    logic [15:0] en_out;
    logic [15:0] en_pwm;
    logic [7:0]  duty;
    logic [7:0]  pwm_cnt;
    logic        period_wrap;
    logic        commit_done;
    logic [3:0]  err_cnt;

    pwm_reg_scheduler #(
        .PRESCALE (1),
        .ERR_W    (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .wr_valid    (wr_valid),
        .wr_ready    (wr_ready),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .en_out      (en_out),
        .en_pwm      (en_pwm),
        .duty        (duty),
        .pwm_cnt     (pwm_cnt),
        .period_wrap (period_wrap),
        .commit_done (commit_done),
        .err_cnt     (err_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] eo;
        logic [15:0] ep;
        logic [7:0]  d;
    } snap_t;

    snap_t sb_q[$];
    int    n_pass  = 0;
    int    n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic expect_snap(input logic [15:0] eo, input logic [15:0] ep, input logic [7:0] d);
        snap_t s;
        s.eo = eo;
        s.ep = ep;
        s.d  = d;
        sb_q.push_back(s);
    endtask

    // Monitor: the active set is complete on the cycle after commit_done.
    initial begin
        snap_t e;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && commit_done === 1'b1) begin
                @(negedge clk);
                if (sb_q.size() == 0) begin
                    n_total++;
                    $display("FAIL commit_unexpected: got a commit_done pulse, expected none");
                end else begin
                    e = sb_q.pop_front();
                    check("commit_en_out", en_out, e.eo);
                    check("commit_en_pwm", en_pwm, e.ep);
                    check("commit_duty", duty, e.d);
                    $display("commit: en_out=%h en_pwm=%h duty=%h", en_out, en_pwm, duty);
                end
            end
        end
    end

    task automatic wait_cnt(input logic [7:0] v);
        int n = 0;
        @(negedge clk);
        while (pwm_cnt !== v && n < 600) begin
            @(negedge clk);
            n++;
        end
        if (n >= 600) begin
            n_total++;
            $display("FAIL wait_cnt_timeout: got pwm_cnt 0x%0h, expected 0x%0h", pwm_cnt, v);
        end
    endtask

    task automatic do_write(input logic [6:0] a, input logic [7:0] d);
        int n = 0;
        @(negedge clk);
        wr_valid = 1'b1;
        wr_addr  = a;
        wr_data  = d;
        while (wr_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) begin
            n_total++;
            $display("FAIL write_timeout: got wr_ready %b, expected 1", wr_ready);
        end
        @(posedge clk);
        #1 wr_valid = 1'b0;
        $display("write: addr=0x%0h data=0x%0h", a, d);
    endtask

    // Called at the negedge of the wrap_evt cycle; watches the next six cycles.
    task automatic boundary_watch(input bit exp_commit, input bit chk_duty, input logic [7:0] hold);
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (k == 1) begin
                check("period_wrap_rise", period_wrap, 1);
                check("pwm_cnt_at_wrap", pwm_cnt, 0);
            end
            if (k == 2) check("period_wrap_fall", period_wrap, 0);
            check("wr_ready_boundary", wr_ready, (exp_commit && k <= 5) ? 0 : 1);
            check("commit_done_pulse", commit_done, (exp_commit && k == 5) ? 1 : 0);
            if (chk_duty && k <= 5) check("duty_held", duty, hold);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish before 200000 ns");
        $fatal(1, "watchdog");
    end

    initial begin
        int lo;
        int n;

        // Reset values
        #2 rst_n = 1'b0;
        #1;
        check("reset_en_out", en_out, 0);
        check("reset_en_pwm", en_pwm, 0);
        check("reset_duty", duty, 0);
        check("reset_pwm_cnt", pwm_cnt, 0);
        check("reset_err_cnt", err_cnt, 0);
        check("reset_period_wrap", period_wrap, 0);
        check("reset_commit_done", commit_done, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1 check("wr_ready_after_reset", wr_ready, 1);

        // Deferred commit of duty
        wait_cnt(8'd10);
        do_write(7'd4, 8'h80);
        expect_snap(16'h0000, 16'h0000, 8'h80);
        wait_cnt(8'd255);
        boundary_watch(1'b1, 1'b1, 8'h00);

        // Multi-register commit, last write wins on addr 2
        wait_cnt(8'd20);
        do_write(7'd0, 8'hFF);
        do_write(7'd2, 8'h0F);
        do_write(7'd2, 8'h3C);
        expect_snap(16'h00FF, 16'h003C, 8'h80);
        wait_cnt(8'd255);
        boundary_watch(1'b1, 1'b1, 8'h80);

        // Write on the boundary cycle with nothing dirty
        wait_cnt(8'd255);
        wr_valid = 1'b1;
        wr_addr  = 7'd3;
        wr_data  = 8'hA5;
        check("ready_on_wrap", wr_ready, 1);
        @(posedge clk);
        #1 wr_valid = 1'b0;
        $display("write: addr=0x3 data=0xa5 (boundary)");
        expect_snap(16'h00FF, 16'hA53C, 8'h80);
        boundary_watch(1'b1, 1'b0, 8'h00);

        // Backpressure during COMMIT
        wait_cnt(8'd30);
        do_write(7'd0, 8'h01);
        expect_snap(16'h0001, 16'hA53C, 8'h80);
        wait_cnt(8'd255);
        @(negedge clk);
        wr_valid = 1'b1;
        wr_addr  = 7'd1;
        wr_data  = 8'h55;
        lo = 0;
        n  = 0;
        while (wr_ready !== 1'b1 && n < 20) begin
            lo++;
            @(negedge clk);
            n++;
        end
        check("backpressure_cycles", lo, 5);
        @(posedge clk);
        #1 wr_valid = 1'b0;
        $display("write: addr=0x1 data=0x55 (held through commit)");
        expect_snap(16'h5501, 16'hA53C, 8'h80);
        wait_cnt(8'd100);
        check("en_out_deferred", en_out, 16'h0001);
        wait_cnt(8'd255);
        boundary_watch(1'b1, 1'b0, 8'h00);

        // Bad addresses: saturate err_cnt, no commit
        wait_cnt(8'd20);
        for (int i = 0; i < 17; i++) do_write(7'(5 + i * 7), 8'(i));
        check("err_cnt_saturated", err_cnt, 15);
        wait_cnt(8'd255);
        boundary_watch(1'b0, 1'b0, 8'h00);
        check("bad_en_out", en_out, 16'h5501);
        check("bad_en_pwm", en_pwm, 16'hA53C);
        check("bad_duty", duty, 8'h80);

        // Reset in the middle of a commit
        wait_cnt(8'd20);
        do_write(7'd0, 8'hAA);
        do_write(7'd4, 8'h11);
        wait_cnt(8'd255);
        @(negedge clk);
        @(negedge clk);
        check("partial_en_out", en_out, 16'h55AA);
        check("partial_duty", duty, 8'h80);
        #2 rst_n = 1'b0;
        #1;
        check("midreset_en_out", en_out, 0);
        check("midreset_en_pwm", en_pwm, 0);
        check("midreset_duty", duty, 0);
        check("midreset_err_cnt", err_cnt, 0);
        check("midreset_pwm_cnt", pwm_cnt, 0);
        check("midreset_commit_done", commit_done, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 check("wr_ready_after_midreset", wr_ready, 1);
        wait_cnt(8'd255);
        boundary_watch(1'b0, 1'b0, 8'h00);
        check("post_reset_en_out", en_out, 0);
        check("post_reset_duty", duty, 0);

        check("scoreboard_drained", sb_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
